// File: rtl/ssram_sp_parity_if.sv
// SRAM-side bus bundle for ssram_sp_parity: address/control/write data in,
// registered read data out.
`timescale 1ns/1ps
interface ssram_sp_parity_if #(
  parameter int AW = 12
);
  logic [AW-1:0] ahb_sram_addr;
  logic          ahb_sram_en;
  logic [3:0]    ahb_sram_enb;
  logic          ahb_sram_we;
  logic [3:0]    ahb_sram_wb;
  logic [31:0]   ahb_sram_din;
  logic [31:0]   sram_ahb_dout;

  modport master (
    output ahb_sram_addr, ahb_sram_en, ahb_sram_enb, ahb_sram_we,
           ahb_sram_wb, ahb_sram_din,
    input  sram_ahb_dout
  );

  modport slave (
    input  ahb_sram_addr, ahb_sram_en, ahb_sram_enb, ahb_sram_we,
           ahb_sram_wb, ahb_sram_din,
    output sram_ahb_dout
  );
endinterface

// File: rtl/ssram_sp_parity.sv
// Single-port 2**AW x 32 synchronous SRAM, byte-strobed writes, 1-cycle reads.
// Optional per-byte even parity with error status: define SSRAM_PARITY_EN.
`timescale 1ns/1ps

module ssram_sp_parity_lane #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  input  logic          inj,
  output logic [7:0]    rdata,
  output logic          perr
);
  localparam int DEPTH = 1 << AW;

  // Storage is never reset so contents survive HRESETn.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge HCLK)
    if (wr) mem[addr] <= wdata;

  assign rdata = mem[addr];

`ifdef SSRAM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge HCLK)
    if (wr) par[addr] <= (^wdata) ^ inj;

  assign perr = par[addr] ^ (^rdata);
`else
  logic unused_inj;
  assign unused_inj = inj;
  assign perr       = 1'b0;
`endif
endmodule

module ssram_sp_parity #(
  parameter int AW = 12
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ssram_sp_parity_if.slave    bus,
  input  logic                par_inj,
  input  logic                err_clr,
  output logic                par_err,
  output logic                err_sticky,
  output logic [AW-1:0]       err_addr,
  output logic [7:0]          err_cnt
);
  localparam int NUM_LANES = 4;

  logic                      rd;
  logic [NUM_LANES-1:0]      lane_wr;
  logic [NUM_LANES-1:0]      lane_perr;
  logic [NUM_LANES-1:0][7:0] lane_rd;

  assign rd = bus.ahb_sram_en & ~bus.ahb_sram_we;

  // Byte enables are not used: only the write strobes select lanes.
  logic unused_enb;
  assign unused_enb = ^bus.ahb_sram_enb;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      // Writes are suppressed while reset is held so an aborted access cannot land.
      assign lane_wr[i] = HRESETn & bus.ahb_sram_en & bus.ahb_sram_we & bus.ahb_sram_wb[i];

      ssram_sp_parity_lane #(.AW(AW)) u_lane (
        .HCLK  (HCLK),
        .wr    (lane_wr[i]),
        .addr  (bus.ahb_sram_addr),
        .wdata (bus.ahb_sram_din[8*i +: 8]),
        .inj   (par_inj),
        .rdata (lane_rd[i]),
        .perr  (lane_perr[i])
      );
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) bus.sram_ahb_dout <= '0;
    else if (rd)  bus.sram_ahb_dout <= lane_rd;

`ifdef SSRAM_PARITY_EN
  logic err_hit;
  assign err_hit = rd & (|lane_perr);

  // A new error beats a simultaneous clear: the count restarts at 1.
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      par_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
      err_cnt    <= '0;
    end else begin
      par_err <= err_hit;
      if (err_hit) begin
        err_sticky <= 1'b1;
        err_addr   <= bus.ahb_sram_addr;
        err_cnt    <= err_clr ? 8'd1 : (err_cnt == 8'hFF ? err_cnt : err_cnt + 8'd1);
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
    end
`else
  logic unused_par;
  assign unused_par = ^{par_inj, err_clr, lane_perr};

  assign par_err    = 1'b0;
  assign err_sticky = 1'b0;
  assign err_addr   = '0;
  assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_ssram_sp_parity.sv
// Scoreboard bench for ssram_sp_parity; expectations follow SSRAM_PARITY_EN.
`timescale 1ns/1ps
module tb_ssram_sp_parity;
  localparam int AW = 12;
`ifdef SSRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b1;
  logic          par_inj = 1'b0;
  logic          err_clr = 1'b0;
  logic          par_err, err_sticky;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_cnt;

  ssram_sp_parity_if #(.AW(AW)) bus();

  ssram_sp_parity #(.AW(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (bus),
    .par_inj    (par_inj),
    .err_clr    (err_clr),
    .par_err    (par_err),
    .err_sticky (err_sticky),
    .err_addr   (err_addr),
    .err_cnt    (err_cnt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0]   dout;
    logic          perr;
    logic          sticky;
    logic [AW-1:0] eaddr;
    logic [7:0]    cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  exp_t        e;
  logic [31:0] mem_m [int];
  logic [3:0]  bad_m [int];
  int          errors = 0;
  int          checks = 0;

  task automatic model_reset();
    m.dout = '0; m.perr = 1'b0; m.sticky = 1'b0; m.eaddr = '0; m.cnt = '0;
  endtask

  // Drive one cycle, advance the model, queue the expected post-edge outputs.
  task automatic drive(input logic en, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] wb,
                       input logic inj, input logic clr);
    logic        err;
    logic [31:0] w;
    logic [3:0]  b;
    bus.ahb_sram_en   = en;
    bus.ahb_sram_we   = we;
    bus.ahb_sram_addr = a;
    bus.ahb_sram_din  = d;
    bus.ahb_sram_wb   = wb;
    bus.ahb_sram_enb  = 4'($urandom);
    par_inj = inj;
    err_clr = clr;
    err = 1'b0;
    m.perr = 1'b0;
    if (en && !we) begin
      m.dout = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0;
      err    = PAR && bad_m.exists(int'(a)) && (|bad_m[int'(a)]);
      m.perr = err;
    end
    if (PAR) begin
      if (err) begin
        m.sticky = 1'b1;
        m.eaddr  = a;
        m.cnt    = clr ? 8'd1 : (m.cnt == 8'd255 ? 8'd255 : m.cnt + 8'd1);
      end else if (clr) begin
        m.sticky = 1'b0;
        m.cnt    = 8'd0;
      end
    end
    if (en && we) begin
      w = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0;
      b = bad_m.exists(int'(a)) ? bad_m[int'(a)] : 4'h0;
      for (int i = 0; i < 4; i++)
        if (wb[i]) begin
          w[8*i +: 8] = d[8*i +: 8];
          b[i]        = inj;
        end
      mem_m[int'(a)] = w;
      bad_m[int'(a)] = b;
    end
    sb.push_back(m);
    @(posedge HCLK);
    #1;
    bus.ahb_sram_en = 1'b0;
    par_inj = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (bus.sram_ahb_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.sram_ahb_dout); end
    repeat (2) @(posedge HCLK);
    #1;
    checks++; if (par_err !== 1'b0)    begin errors++; $display("FAIL reset_par_err got=%b exp=0", par_err); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", err_sticky); end
    checks++; if (err_addr !== '0)     begin errors++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    checks++; if (err_cnt !== 8'd0)    begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_write_read();
    drive(1, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0);
    e = sb.pop_front();
    checks++; if (bus.sram_ahb_dout !== e.dout) begin errors++; $display("FAIL wr_hold got=%h exp=%h", bus.sram_ahb_dout, e.dout); end
    drive(1, 0, 12'h010, 32'h0, 4'h0, 0, 0);
    e = sb.pop_front();
    checks++; if (bus.sram_ahb_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_010 got=%h exp=deadbeef", bus.sram_ahb_dout); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rd_010_perr got=%b exp=0", par_err); end
  endtask

  task automatic test_strobes();
    drive(1, 1, 12'h020, 32'hFFFFFFFF, 4'hF, 0, 0);
    void'(sb.pop_front());
    drive(1, 1, 12'h020, 32'h00000000, 4'b0101, 0, 0);
    void'(sb.pop_front());
    drive(1, 1, 12'h020, 32'h12345678, 4'b0000, 0, 0);
    void'(sb.pop_front());
    drive(1, 0, 12'h020, 32'h0, 4'h0, 0, 0);
    e = sb.pop_front();
    checks++; if (bus.sram_ahb_dout !== 32'hFF00FF00) begin errors++; $display("FAIL strobe_rd got=%h exp=ff00ff00", bus.sram_ahb_dout); end
    checks++; if (bus.sram_ahb_dout !== e.dout) begin errors++; $display("FAIL strobe_model got=%h exp=%h", bus.sram_ahb_dout, e.dout); end
  endtask

  task automatic test_hold();
    drive(1, 0, 12'h010, 32'h0, 4'h0, 0, 0);
    void'(sb.pop_front());
    drive(1, 1, 12'h020, 32'hCAFEF00D, 4'hF, 0, 0);
    void'(sb.pop_front());
    checks++; if (bus.sram_ahb_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_write got=%h exp=deadbeef", bus.sram_ahb_dout); end
    drive(0, 0, 12'h010, 32'h0, 4'h0, 0, 0);
    void'(sb.pop_front());
    checks++; if (bus.sram_ahb_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_idle got=%h exp=deadbeef", bus.sram_ahb_dout); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, AW'(12'h100 + i), $urandom, 4'hF, 0, 0);
      void'(sb.pop_front());
      // read-after-write on the very next cycle
      drive(1, 0, AW'(12'h100 + i), 32'h0, 4'h0, 0, 0);
      e = sb.pop_front();
      checks++; if (bus.sram_ahb_dout !== e.dout) begin errors++; $display("FAIL raw_%0d got=%h exp=%h", i, bus.sram_ahb_dout, e.dout); end
    end
    for (int i = 7; i >= 0; i--) begin
      drive(1, 0, AW'(12'h100 + i), 32'h0, 4'h0, 0, 0);
      e = sb.pop_front();
      checks++; if (bus.sram_ahb_dout !== e.dout || par_err !== e.perr)
        begin errors++; $display("FAIL b2b_%0d got=%h/%b exp=%h/%b", i, bus.sram_ahb_dout, par_err, e.dout, e.perr); end
    end
  endtask

  task automatic test_parity_inj();
    drive(1, 1, 12'h030, 32'h11223344, 4'hF, 0, 0);
    void'(sb.pop_front());
    drive(1, 1, 12'h030, 32'h000000A5, 4'b0001, 1, 0);
    void'(sb.pop_front());
    drive(1, 0, 12'h030, 32'h0, 4'h0, 0, 0);
    void'(sb.pop_front());
    checks++; if (bus.sram_ahb_dout !== 32'h112233A5) begin errors++; $display("FAIL inj_data got=%h exp=112233a5", bus.sram_ahb_dout); end
    checks++; if (par_err !== PAR)    begin errors++; $display("FAIL inj_perr got=%b exp=%b", par_err, PAR); end
    checks++; if (err_sticky !== PAR) begin errors++; $display("FAIL inj_sticky got=%b exp=%b", err_sticky, PAR); end
    checks++; if (err_addr !== (PAR ? AW'(12'h030) : AW'(0))) begin errors++; $display("FAIL inj_addr got=%h", err_addr); end
    checks++; if (err_cnt !== (PAR ? 8'd1 : 8'd0)) begin errors++; $display("FAIL inj_cnt got=%0d exp=%0d", err_cnt, PAR ? 1 : 0); end
    drive(0, 0, 12'h000, 32'h0, 4'h0, 0, 0);
    void'(sb.pop_front());
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL inj_pulse got=%b exp=0", par_err); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 12'h030, 32'h0, 4'h0, 0, 0);
      e = sb.pop_front();
      checks++; if (err_cnt !== e.cnt || par_err !== e.perr)
        begin errors++; $display("FAIL sat_%0d cnt=%0d perr=%b exp=%0d/%b", i, err_cnt, par_err, e.cnt, e.perr); end
    end
    checks++; if (err_cnt !== (PAR ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_cnt got=%0d", err_cnt); end
    drive(1, 0, 12'h030, 32'h0, 4'h0, 0, 1);
    void'(sb.pop_front());
    checks++; if (err_cnt !== (PAR ? 8'd1 : 8'd0)) begin errors++; $display("FAIL clr_vs_err_cnt got=%0d", err_cnt); end
    checks++; if (err_sticky !== PAR) begin errors++; $display("FAIL clr_vs_err_sticky got=%b", err_sticky); end
    drive(0, 0, 12'h000, 32'h0, 4'h0, 0, 1);
    e = sb.pop_front();
    checks++; if (err_cnt !== 8'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL clr_only cnt=%0d sticky=%b", err_cnt, err_sticky); end
    checks++; if (err_addr !== e.eaddr) begin errors++; $display("FAIL clr_keep_addr got=%h exp=%h", err_addr, e.eaddr); end
  endtask

  task automatic test_reset_retention();
    drive(1, 1, 12'h040, 32'h12345678, 4'hF, 0, 0);
    void'(sb.pop_front());
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    checks++; if (bus.sram_ahb_dout !== 32'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", bus.sram_ahb_dout); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();
    @(posedge HCLK);
    #1;
    drive(1, 0, 12'h040, 32'h0, 4'h0, 0, 0);
    void'(sb.pop_front());
    checks++; if (bus.sram_ahb_dout !== 32'h12345678) begin errors++; $display("FAIL rst_keep got=%h exp=12345678", bus.sram_ahb_dout); end
    drive(1, 0, 12'h030, 32'h0, 4'h0, 0, 0);
    e = sb.pop_front();
    checks++; if (par_err !== e.perr || err_cnt !== e.cnt) begin errors++; $display("FAIL rst_par_kept perr=%b cnt=%0d exp=%b/%0d", par_err, err_cnt, e.perr, e.cnt); end
  endtask

  initial begin
    bus.ahb_sram_en   = 1'b0;
    bus.ahb_sram_we   = 1'b0;
    bus.ahb_sram_addr = '0;
    bus.ahb_sram_din  = '0;
    bus.ahb_sram_wb   = '0;
    bus.ahb_sram_enb  = '0;
    model_reset();
    test_reset();
    test_write_read();
    test_strobes();
    test_hold();
    test_back_to_back();
    test_parity_inj();
    test_saturate();
    test_reset_retention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ssram_sp_parity.md
SSRAM_SP_PARITY -- requirements
Module: ssram_sp_parity

Interface
REQ-001 The block SHALL have parameter AW, default 12, giving the word-address width; depth is 2**AW 32-bit words.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, HCLK and HRESETn, listed first.
REQ-003 HCLK  input  1  clock; all state SHALL update on its rising edge.
REQ-004 HRESETn  input  1  asynchronous active-low reset.
REQ-005 ahb_sram_addr  input  AW  word address.
REQ-006 ahb_sram_en  input  1  access enable.
REQ-007 ahb_sram_enb  input  4  byte-lane enables; ignored by this block.
REQ-008 ahb_sram_we  input  1  1 = write, 0 = read (when en=1).
REQ-009 ahb_sram_wb  input  4  per-byte write strobes; bit i covers din[8i+7:8i].
REQ-010 ahb_sram_din  input  32  write data.
REQ-011 sram_ahb_dout  output  32  registered read data.
REQ-012 par_inj  input  1  when 1 on a write, the stored parity of every written lane SHALL be inverted.
REQ-013 err_clr  input  1  synchronous clear of the error status.
REQ-014 par_err  output  1  one-cycle pulse, aligned with sram_ahb_dout, flagging a parity mismatch.
REQ-015 err_sticky  output  1  set on any parity error; held until cleared.
REQ-016 err_addr  output  AW  address of the most recent parity-error read.
REQ-017 err_cnt  output  8  saturating parity-error count.

Function
REQ-018 Write: en=1, we=1 at an edge SHALL update only lanes with wb[i]=1 of mem[addr]; wb=4'b0000 SHALL leave memory unchanged.
REQ-019 Read: en=1, we=0 at edge N SHALL load the full 32-bit mem[addr] into sram_ahb_dout, visible after edge N (1-cycle latency).
REQ-020 sram_ahb_dout SHALL hold its last value in every cycle that is not a read, including write cycles.
REQ-021 Back-to-back reads SHALL sustain one word per cycle with no bubbles.
REQ-022 A read of an address written in the previous cycle SHALL return the newly written data.
REQ-023 Each lane SHALL store an even-parity bit (XOR of its 8 data bits, inverted if par_inj=1), updated only when that lane is written.
REQ-024 On a read, parity SHALL be recomputed per lane; any mismatch SHALL raise par_err for exactly the cycle sram_ahb_dout presents that word.
REQ-025 On a mismatch, err_sticky SHALL be set, err_addr SHALL capture the read address, and err_cnt SHALL increment, saturating at 255.
REQ-026 err_clr=1 SHALL clear err_sticky and err_cnt to 0; err_addr SHALL be retained.
REQ-027 If err_clr and a new error occur at the same edge, the error SHALL win: err_sticky=1 and err_cnt=1.
REQ-028 Memory and parity contents SHALL be undefined until written; only written words are checked.

Reset
REQ-029 HRESETn=0 SHALL asynchronously force sram_ahb_dout=32'h0, par_err=0, err_sticky=0, err_addr=0, and err_cnt=0.
REQ-030 Reset SHALL NOT clear memory or parity storage; contents written before reset SHALL be readable after it.
REQ-031 Reset asserted mid-access SHALL abort that access; no memory update SHALL be guaranteed for the edge at which reset is asserted.

Configuration
REQ-032 Macro SSRAM_PARITY_EN SHALL control the parity feature.
REQ-033 With SSRAM_PARITY_EN defined, REQ-023 to REQ-027 SHALL apply.
REQ-034 Without SSRAM_PARITY_EN, no parity storage SHALL be built; par_inj and err_clr SHALL be ignored; par_err, err_sticky, err_addr and err_cnt SHALL be constant 0; data behaviour SHALL be unchanged.

Verification
REQ-035 Write addr 0x010 din 0xDEADBEEF wb=1111, then read 0x010 -> dout=0xDEADBEEF one cycle after the read edge, par_err=0.
REQ-036 Write 0xFFFFFFFF wb=1111 to 0x020, then 0x00000000 wb=0101 to 0x020, then read -> dout=0xFF00FF00.
REQ-037 Read 0x010, then write 0x020, then idle -> dout holds 0xDEADBEEF through the write and idle cycles.
REQ-038 Write 0x030 with par_inj=1 wb=0001, then read 0x030 -> par_err pulses one cycle, err_sticky=1, err_addr=0x030, err_cnt=1.
REQ-039 Perform 300 erroring reads -> err_cnt=255; then assert err_clr together with an erroring read -> err_cnt=1, err_sticky=1.
REQ-040 Write 0x040=0x12345678, pulse HRESETn low for 1 cycle, then read 0x040 -> dout=0 during reset, 0x12345678 after the read; build without SSRAM_PARITY_EN and rerun REQ-038 -> par_err stays 0.
